// File: rtl/io_pkg.sv
// Shared types and constants for the IN/OUT handshake unit.
// Opcode constants are exported for benches and decode tables.
package io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_REL,
    WAIT_PRESS,
    DEBOUNCE,
    DONE
  } io_state_t;

  localparam logic [5:0] OP_IN      = 6'b001000;
  localparam logic [5:0] OP_OUT     = 6'b001001;
  localparam logic [1:0] MEM2REG_IO = 2'b01;

endpackage

// File: rtl/io_btn_debounce.sv
// Confirm-button synchronizer and saturating press counter.
// The counter only runs while armed by the handshake FSM.
module io_btn_debounce #(
  parameter int DEB_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_raw,
  input  logic arm,
  output logic btn_s,
  output logic pressed
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES);

  logic [1:0]       sync_q;
  logic [1:0]       vld_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      vld_q  <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      vld_q  <= {vld_q[0], 1'b1};
      cnt_q  <= cnt_d;
    end
  end

  // Until the synchronizer has refilled after reset, treat the
  // button as held so a still-pressed button needs a real release.
  assign btn_s = sync_q[1] | ~vld_q[1];

  always_comb begin
    cnt_d = '0;
    if (arm && btn_s) begin
      cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end
  end

  assign pressed = arm & btn_s & (cnt_q == CNT_MAX);

endmodule

// File: rtl/io_handshake_unit.sv
// IN/OUT responder: stalls on IN until a debounced confirm press,
// captures the switches for one commit cycle, latches OUT data.
module io_handshake_unit
  import io_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int SW_W       = 16,
  parameter int DISP_W     = 32,
  parameter int DEB_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              op_io,
  input  logic              halt_req,
  input  logic              reg_write,
  input  logic [SW_W-1:0]   switches,
  input  logic              confirm_btn,
  input  logic [DATA_W-1:0] out_data,
  output logic              stall,
  output logic [DATA_W-1:0] in_data,
  output logic              in_valid,
  output logic [DISP_W-1:0] out_reg,
  output logic              out_valid,
  output logic              busy
);

  if (SW_W > DATA_W || DISP_W > DATA_W || DEB_CYCLES < 1) begin : g_bad
    $error("io_handshake_unit: illegal parameters");
  end

  logic              in_req;
  logic              out_req;
  logic              arm;
  logic              btn_s;
  logic              pressed;
  logic              capture;
  io_state_t         state_q;
  io_state_t         state_d;
  logic [DATA_W-1:0] in_data_q;
  logic [DISP_W-1:0] out_reg_q;
  logic              out_valid_q;

  assign in_req  = op_io & halt_req;
  assign out_req = op_io & ~halt_req & ~reg_write;
  assign arm     = in_req &
                   (state_q == WAIT_PRESS || state_q == DEBOUNCE);

  io_btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clock  (clock),
    .reset  (reset),
    .btn_raw(confirm_btn),
    .arm    (arm),
    .btn_s  (btn_s),
    .pressed(pressed)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (state_q != IDLE && !in_req) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:       if (in_req) state_d = WAIT_REL;
        WAIT_REL:   if (!btn_s) state_d = WAIT_PRESS;
        WAIT_PRESS: if (btn_s)  state_d = DEBOUNCE;
        DEBOUNCE: begin
          if (!btn_s) begin
            state_d = WAIT_PRESS;
          end else if (pressed) begin
            capture = 1'b1;
            state_d = DONE;
          end
        end
        DONE:       state_d = IDLE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      in_data_q   <= '0;
      out_reg_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_req;
      if (capture) in_data_q <= DATA_W'(switches);
      if (out_req) out_reg_q <= out_data[DISP_W-1:0];
    end
  end

  assign stall     = in_req & (state_q != DONE);
  assign in_valid  = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign in_data   = in_data_q;
  assign out_reg   = out_reg_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_io_handshake_unit.sv
// Directed bench for io_handshake_unit with DEB_CYCLES=4.
// Table vectors cover IN/OUT basics; tasks cover multi-cycle cases.
module tb_io_handshake_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        op_io = 1'b0;
  logic        halt_req = 1'b0;
  logic        reg_write = 1'b0;
  logic [15:0] switches = '0;
  logic        confirm_btn = 1'b0;
  logic [31:0] out_data = '0;
  logic        stall;
  logic [31:0] in_data;
  logic        in_valid;
  logic [31:0] out_reg;
  logic        out_valid;
  logic        busy;

  int nvec = 0;
  int nmis = 0;

  io_handshake_unit #(
    .DATA_W(32), .SW_W(16), .DISP_W(32), .DEB_CYCLES(4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .op_io      (op_io),
    .halt_req   (halt_req),
    .reg_write  (reg_write),
    .switches   (switches),
    .confirm_btn(confirm_btn),
    .out_data   (out_data),
    .stall      (stall),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .out_reg    (out_reg),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        op;
    logic        hlt;
    logic        rw;
    logic [15:0] sw;
    logic        btn;
    logic [31:0] od;
    logic        e_stall;
    logic        e_val;
    logic [31:0] e_data;
    logic [31:0] e_out;
    logic        e_ov;
    logic        e_busy;
  } vec_t;

  vec_t tv[17];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic run_in(input string nm, input logic [31:0] pat,
                        input int n, input logic [15:0] swa,
                        input logic [15:0] swb, input int chg,
                        input logic [31:0] prev, input int efirst);
    int pulses;
    int first;
    int bad;
    logic [31:0] cap;
    logic [31:0] pre;
    pulses = 0;
    first = -1;
    bad = 0;
    cap = '0;
    pre = '0;
    op_io = 1'b1;
    halt_req = 1'b1;
    reg_write = 1'b1;
    for (int i = 0; i < n; i++) begin
      confirm_btn = pat[i];
      switches = (i >= chg) ? swb : swa;
      #1;
      if (in_valid) begin
        pulses++;
        if (first < 0) begin
          first = i;
          cap = in_data;
        end
      end
      if (stall !== ~in_valid) bad++;
      if (i == efirst - 1) pre = in_data;
      step();
    end
    op_io = 1'b0;
    halt_req = 1'b0;
    reg_write = 1'b0;
    confirm_btn = 1'b0;
    chk({nm, " pulses"}, pulses, 1);
    chk({nm, " pulse cycle"}, first, efirst);
    chk({nm, " captured"}, cap, {16'h0, swb});
    chk({nm, " data before"}, pre, prev);
    chk({nm, " stall/valid"}, bad, 0);
    repeat (3) step();
  endtask

  initial begin
    int pulses;
    tv[0]  = '{1, 1, 1, 16'h00A5, 0, 32'h0, 1, 0, 32'h0, 32'h0, 0, 0};
    tv[1]  = '{1, 1, 1, 16'h00A5, 0, 32'h0, 1, 0, 32'h0, 32'h0, 0, 1};
    tv[2]  = '{1, 1, 1, 16'h00A5, 0, 32'h0, 1, 0, 32'h0, 32'h0, 0, 1};
    tv[3]  = '{1, 1, 1, 16'h00A5, 1, 32'h0, 1, 0, 32'h0, 32'h0, 0, 1};
    tv[4]  = '{1, 1, 1, 16'h00A5, 1, 32'h0, 1, 0, 32'h0, 32'h0, 0, 1};
    tv[5]  = '{1, 1, 1, 16'h00A5, 1, 32'h0, 1, 0, 32'h0, 32'h0, 0, 1};
    tv[6]  = '{1, 1, 1, 16'h00A5, 1, 32'h0, 1, 0, 32'h0, 32'h0, 0, 1};
    tv[7]  = '{1, 1, 1, 16'h00A5, 1, 32'h0, 1, 0, 32'h0, 32'h0, 0, 1};
    tv[8]  = '{1, 1, 1, 16'h00A5, 1, 32'h0, 1, 0, 32'h0, 32'h0, 0, 1};
    tv[9]  = '{1, 1, 1, 16'h00A5, 1, 32'h0, 1, 0, 32'h0, 32'h0, 0, 1};
    tv[10] = '{1, 1, 1, 16'h00A5, 1, 32'h0, 0, 1, 32'hA5, 32'h0, 0, 1};
    tv[11] = '{0, 0, 0, 16'h00A5, 0, 32'h0, 0, 0, 32'hA5, 32'h0, 0, 0};
    tv[12] = '{1, 0, 0, 16'h00A5, 0, 32'hDEADBEEF,
               0, 0, 32'hA5, 32'h0, 0, 0};
    tv[13] = '{0, 0, 0, 16'h00A5, 0, 32'h0,
               0, 0, 32'hA5, 32'hDEADBEEF, 1, 0};
    tv[14] = '{1, 0, 1, 16'h00A5, 0, 32'h12345678,
               0, 0, 32'hA5, 32'hDEADBEEF, 0, 0};
    tv[15] = '{0, 0, 0, 16'h00A5, 0, 32'h0,
               0, 0, 32'hA5, 32'hDEADBEEF, 0, 0};
    tv[16] = '{0, 1, 0, 16'h00A5, 0, 32'h0,
               0, 0, 32'hA5, 32'hDEADBEEF, 0, 0};

    #1 reset = 1'b1;
    #2;
    chk("rst in_data", in_data, 32'h0);
    chk("rst out_reg", out_reg, 32'h0);
    chk("rst in_valid", in_valid, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst stall idle", stall, 0);
    op_io = 1'b1;
    halt_req = 1'b1;
    #1 chk("rst stall in_req", stall, 1);
    op_io = 1'b0;
    halt_req = 1'b0;
    @(posedge clock);
    #2 reset = 1'b0;
    repeat (3) step();

    for (int i = 0; i < 17; i++) begin
      op_io = tv[i].op;
      halt_req = tv[i].hlt;
      reg_write = tv[i].rw;
      switches = tv[i].sw;
      confirm_btn = tv[i].btn;
      out_data = tv[i].od;
      #1;
      chk($sformatf("v%0d stall", i), stall, tv[i].e_stall);
      chk($sformatf("v%0d in_valid", i), in_valid, tv[i].e_val);
      chk($sformatf("v%0d in_data", i), in_data, tv[i].e_data);
      chk($sformatf("v%0d out_reg", i), out_reg, tv[i].e_out);
      chk($sformatf("v%0d out_valid", i), out_valid, tv[i].e_ov);
      chk($sformatf("v%0d busy", i), busy, tv[i].e_busy);
      step();
    end
    op_io = 1'b0;
    halt_req = 1'b0;
    confirm_btn = 1'b0;
    repeat (3) step();

    run_in("bounce", 32'h0000_07EC, 16, 16'h1234, 16'h5A5A, 8,
           32'h5A5A ^ 32'h5AFF, 12);

    confirm_btn = 1'b1;
    repeat (3) step();
    run_in("held", 32'h003F_FCFF, 22, 16'h0F0F, 16'h0F0F, 99,
           32'h5A5A, 17);

    op_io = 1'b1;
    halt_req = 1'b1;
    reg_write = 1'b1;
    confirm_btn = 1'b0;
    repeat (2) step();
    confirm_btn = 1'b1;
    repeat (4) step();
    #1 chk("pre-reset busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid rst in_data", in_data, 32'h0);
    chk("mid rst out_reg", out_reg, 32'h0);
    chk("mid rst busy", busy, 0);
    chk("mid rst in_valid", in_valid, 0);
    chk("mid rst stall", stall, 1);
    @(posedge clock);
    #2 reset = 1'b0;
    run_in("post-reset", 32'h003F_FCFF, 22, 16'h00A5, 16'h00A5, 99,
           32'h0, 17);

    op_io = 1'b1;
    halt_req = 1'b1;
    reg_write = 1'b1;
    confirm_btn = 1'b0;
    repeat (3) step();
    #1 chk("flush pre busy", busy, 1);
    op_io = 1'b0;
    halt_req = 1'b0;
    #1 chk("flush stall", stall, 0);
    step();
    #1;
    chk("flush busy", busy, 0);
    chk("flush in_valid", in_valid, 0);
    chk("flush in_data", in_data, 32'hA5);
    pulses = 0;
    confirm_btn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      #1 if (in_valid) pulses++;
    end
    chk("flush no pulse", pulses, 0);
    chk("flush data kept", in_data, 32'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/io_handshake_unit.md
Name: io_handshake_unit

Overview:
- Responder to the control unit's IN/OUT decode.
- On IN (OpIO=1, Halt=1), it stalls the core until the user presses the confirm button. It then debounces the press, captures the switch value and presents it on the Mem2Reg=01 writeback path for exactly one commit cycle.
- On OUT, it latches the register operand into the display register.
- Sits between the control unit/datapath and the board switches, button and display.

Parameters:
- DATA_W, 32, writeback/operand data width.
- SW_W, 16, switch bank width; must satisfy SW_W <= DATA_W.
- DISP_W, 32, display register width; must satisfy DISP_W <= DATA_W.
- DEB_CYCLES, 50000, consecutive synchronized-high cycles that count as a valid press; must be >= 1.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- op_io  in  1  OpIO from control unit
- halt_req  in  1  Halt from control unit (asserted only for IN)
- reg_write  in  1  RegWrite from control unit
- switches  in  SW_W  raw board switches
- confirm_btn  in  1  raw confirm button, active-high, asynchronous to clock
- out_data  in  DATA_W  register operand for OUT
- stall  out  1  holds PC/fetch while an IN is pending
- in_data  out  DATA_W  captured switch value, zero-extended
- in_valid  out  1  one-cycle commit strobe for IN writeback
- out_reg  out  DISP_W  display register
- out_valid  out  1  high in cycles where out_reg is loaded
- busy  out  1  FSM not in IDLE

Behaviour:
- Decode:
  - in_req = op_io & halt_req.
  - out_req = op_io & ~halt_req & ~reg_write.
  - in_req has priority if both are ever asserted.
- Button sync: 2-flop synchronizer on confirm_btn gives btn_s, so there is 2 cycles of sync latency. Switches are sampled directly at capture time; they are user-static.
- FSM states: IDLE, WAIT_REL, WAIT_PRESS, DEBOUNCE, DONE.
  - IDLE: if in_req, go to WAIT_REL.
  - WAIT_REL: stay while btn_s=1, so a held-over press is not reused. When btn_s=0, go to WAIT_PRESS.
  - WAIT_PRESS: on btn_s=1, go to DEBOUNCE with cnt=1.
  - DEBOUNCE:
    - If btn_s=0, go to WAIT_PRESS and clear cnt.
    - Else if cnt==DEB_CYCLES, set in_data <= {zeros, switches} and go to DONE.
    - Else cnt++.
  - DONE: unconditionally go to IDLE.
  - If in_req drops in any non-IDLE state (e.g. flush), go to IDLE and clear cnt. No in_valid is produced and in_data is unchanged.
- Outputs:
  - stall = in_req & (state != DONE), combinational. It is high from the first cycle the IN opcode is present.
  - in_valid = (state == DONE), registered-state decode. The writeback commits on the clock edge ending the DONE cycle, when stall=0 so the PC advances.
  - in_data holds its value until the next capture.
  - busy = (state != IDLE).
- OUT handling:
  - In any cycle where out_req=1, out_reg <= out_data[DISP_W-1:0] and out_valid=1 (registered, visible the next cycle).
  - Otherwise out_valid=0 and out_reg holds.
  - OUT never stalls and is independent of the IN FSM.
- Back-to-back INs:
  - The second IN enters WAIT_REL the cycle after DONE and requires a release before the new press.
- Counter: sized clog2(DEB_CYCLES+1) bits and saturates; it never wraps.
- Reset (async, including mid-handshake):
  - state=IDLE, cnt=0, sync flops=0.
  - in_data=0, in_valid=0, out_reg=0, out_valid=0, busy=0.
  - stall follows its combinational equation (1 if in_req is present).

Decomposition:
- Shared package io_pkg holds:
  - the state enum io_state_t;
  - opcode constants OP_IN=6'b001000 and OP_OUT=6'b001001, for benches;
  - the MEM2REG_IO=2'b01 constant.
- One sub-module, io_btn_debounce, owns the synchronizer, counter and press-detect. Its interface is clock, reset, btn_raw, arm, pressed. The top module keeps the FSM, capture and OUT register.

Test Plan (DEB_CYCLES=4):
- Basic IN: in_req=1, switches=16'h00A5, button low 3 cycles then high 10 cycles -> stall=1 throughout, one in_valid pulse, in_data=32'h000000A5, stall=0 only in the DONE cycle.
- Bounce: button high 2 cycles, low 1, high 6 -> exactly one in_valid after 4 consecutive synced-high cycles; switch changes made before capture are reflected.
- Held-over press: button already high when in_req rises -> no capture until a release then a new 4-cycle press; in_data updates only after that.
- OUT: op_io=1, halt_req=0, reg_write=0, out_data=32'hDEADBEEF for 1 cycle -> out_reg=32'hDEADBEEF next cycle, out_valid=1 for 1 cycle, stall=0.
- Reset mid-DEBOUNCE: assert reset asynchronously at cnt=2 -> immediately state=IDLE, in_data=0 and out_reg=0. After release, with in_req still high, a full release-plus-press sequence is required.
- Flush: in_req drops during WAIT_PRESS -> IDLE next cycle, no in_valid, in_data unchanged (previous value 32'h000000A5 retained).
